// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The address legality check sits here so that later bus arbiters apply the same rule.
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int NUM_REQ = 2;

    // A byte address is legal when it is word aligned and its word index is below depth.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two requesters and the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    import dmem_arb_pkg::*;

    // Handshake: requester n raises req_valid[n] and holds we/lock/addr/wdata stable;
    // the transfer happens in the cycle where req_valid[n] & req_ready[n]. Exactly one
    // cycle later rsp_valid[n] pulses for one cycle with rsp_err/rsp_rdata qualified by it.
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ-1:0][31:0]       req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic                           rsp_err;
    logic [DATA_W-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-input round-robin grant with its own pointer; after any accepted grant the
// pointer moves to the requester that was not granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx,
    output logic       ptr
);

    logic ptr_q;

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ptr_q;
            grant     = ptr_q ? 2'b10 : 2'b01;
        end else if (req[1]) begin
            grant_idx = 1'b1;
            grant     = 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= ~grant_idx;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one single-port data memory between two requesters,
// with round-robin fairness, an optional bus lock with idle timeout, and address checking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus,
    output logic              mem_write,
    output logic              mem_read,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output arb_state_e        dbg_state,
    output logic              dbg_rr_ptr
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              gidx;
    logic              accept;
    logic              legal;
    logic              rr_ptr;
    logic [1:0]        rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // While locked only the owner may compete; reset blocks every grant.
    always_comb begin
        eligible = bus.req_valid;
        if (state_q == LOCK) begin
            eligible = bus.req_valid & (owner_q ? 2'b10 : 2'b01);
        end
        if (reset) begin
            eligible = 2'b00;
        end
    end

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (eligible),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (gidx),
        .ptr       (rr_ptr)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign legal         = addr_legal(bus.req_addr[gidx], DEPTH);

    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        if (accept) begin
            mem_addr  = bus.req_addr[gidx];
            mem_wd    = bus.req_wdata[gidx];
            mem_write = bus.req_we[gidx] & legal;
            mem_read  = ~bus.req_we[gidx] & legal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (accept && bus.req_lock[gidx]) begin
                    state_d = LOCK;
                    owner_d = gidx;
                    cnt_d   = '0;
                end
            end
            LOCK: begin
                if (accept) begin
                    cnt_d = '0;
                    if (!bus.req_lock[gidx]) begin
                        state_d = ARB;
                    end
                end else if (!bus.req_valid[owner_q]) begin
                    // The owner's last idle cycle before timeout hands the bus back.
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= grant;
            rsp_err_q   <= accept & ~legal;
            rsp_rdata_q <= (accept && legal && !bus.req_we[gidx]) ? mem_rd : '0;
        end
    end

    // A response still in flight when reset arrives is dropped immediately.
    assign bus.rsp_valid = rsp_valid_q & {2{~reset}};
    assign bus.rsp_err   = rsp_err_q & ~reset;
    assign bus.rsp_rdata = reset ? '0 : rsp_rdata_q;

    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random two-requester traffic,
// checked each cycle against an abstract arbitration/memory model and a response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DATA_W       = 32;
    localparam int DEPTH        = 32;
    localparam int LOCK_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_write, mem_read;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wd, mem_rd;
    arb_state_e        dbg_state;
    logic              dbg_rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .dbg_state (dbg_state),
        .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Memory seen by the DUT: combinational read, write at the clock edge.
    logic [DATA_W-1:0] tb_mem [DEPTH];
    assign mem_rd = tb_mem[mem_addr[6:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_addr[6:2]] <= mem_wd;

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int owner    = -1;
    int idle     = 0;
    int favoured = 0;
    logic [DATA_W:0] exp_q [2][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decide the grant from the arbitration rules and predict memory + response.
    always @(negedge clk) begin : model
        int g;
        logic [31:0] a;
        logic legal, we;
        logic [1:0] exp_ready;
        logic [33:0] exp_ctl;
        logic [DATA_W-1:0] exp_wd, rd;
        g = -1;
        if (reset) begin
            owner = -1; idle = 0; favoured = 0;
        end else if (owner >= 0) begin
            if (bus.req_valid[owner]) g = owner;
        end else if (bus.req_valid == 2'b11) g = favoured;
        else if (bus.req_valid[0]) g = 0;
        else if (bus.req_valid[1]) g = 1;

        exp_ready = 2'b00;
        exp_ctl   = '0;
        exp_wd    = '0;
        if (g >= 0) begin
            a  = bus.req_addr[g];
            we = bus.req_we[g];
            legal = (longint'(a) % 4 == 0) && (longint'(a) / 4 < DEPTH);
            exp_ready[g] = 1'b1;
            exp_ctl = {we & legal, ~we & legal, a};
            exp_wd  = bus.req_wdata[g];
            rd = (!we && legal) ? ref_mem[a / 4] : '0;
            exp_q[g].push_back({~legal, rd});
            if (we && legal) ref_mem[a / 4] = bus.req_wdata[g];
            favoured = 1 - g;
            if (owner < 0) begin
                if (bus.req_lock[g]) begin owner = g; idle = 0; end
            end else begin
                idle = 0;
                if (!bus.req_lock[g]) owner = -1;
            end
        end else if (owner >= 0) begin
            idle++;
            if (idle == LOCK_TIMEOUT) begin owner = -1; idle = 0; end
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("mem_ctl", 64'({mem_write, mem_read, mem_addr}), 64'(exp_ctl));
        check("mem_wd", 64'(mem_wd), 64'(exp_wd));
    end

    // Monitor: responses appear one cycle after acceptance.
    always @(posedge clk) begin : monitor
        logic [DATA_W:0] e;
        #2;
        if (reset) begin
            check("rsp_valid_in_reset", 64'(bus.rsp_valid), 64'd0);
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (exp_q[n].size() > 0) begin
                    e = exp_q[n].pop_front();
                    check($sformatf("rsp_valid%0d", n), 64'(bus.rsp_valid[n]), 64'd1);
                    check("rsp_err", 64'(bus.rsp_err), 64'(e[DATA_W]));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e[DATA_W-1:0]));
                end else begin
                    check($sformatf("rsp_idle%0d", n), 64'(bus.rsp_valid[n]), 64'd0);
                end
            end
        end
    end

    // Present a request and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic issue(input int n, input logic we, input logic lock, input logic [31:0] addr,
                         input logic [DATA_W-1:0] wdata, output int stalls);
        logic done;
        bus.req_we[n] = we; bus.req_lock[n] = lock;
        bus.req_addr[n] = addr; bus.req_wdata[n] = wdata;
        bus.req_valid[n] = 1'b1;
        stalls = 0;
        done = 1'b0;
        while (!done && stalls <= 100) begin
            @(negedge clk);
            if (bus.req_ready[n]) done = 1'b1;
            else stalls++;
        end
        check($sformatf("accepted%0d", n), 64'(done), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[n] = 1'b0;
    endtask

    task automatic rand_traffic(input int n, input int count);
        int s, k;
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            repeat (($urandom_range(0, 15) == 0) ? 10 : $urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            k = $urandom_range(0, 9);
            if (k == 0) a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
            else if (k == 1) a = 32'(DEPTH * 4) + ($urandom_range(0, 63) << 2);
            else a = $urandom_range(0, DEPTH - 1) << 2;
            issue(n, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, $urandom, s);
        end
    endtask

    initial begin : driver
        int s0, s1, sum0, sum1;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        reset = 1'b1;
        bus.req_valid = '0; bus.req_we = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", 64'(dbg_state), 64'(ARB));
        check("reset_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_mem", 64'({mem_write, mem_read, mem_addr}), 64'd0);

        // Write then immediately read the same word.
        issue(0, 1'b1, 1'b0, 32'h08, 32'hDEADBEEF, s0);
        issue(0, 1'b0, 1'b0, 32'h08, 32'h0, s0);
        check("raw_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        check("raw_err", 64'(bus.rsp_err), 64'd0);

        // Both requesters continuously valid: grants alternate starting with r1.
        sum0 = 0; sum1 = 0;
        fork
            begin repeat (4) begin issue(0, 1'b0, 1'b0, 32'h00, 32'h0, s0); sum0 += s0; end end
            begin repeat (4) begin issue(1, 1'b0, 1'b0, 32'h04, 32'h0, s1); sum1 += s1; end end
        join
        check("alt_stalls_r0", 64'(sum0), 64'd4);
        check("alt_stalls_r1", 64'(sum1), 64'd3);

        // Locked burst of three writes by r1 while r0 waits.
        fork
            begin
                issue(1, 1'b1, 1'b1, 32'h10, 32'h1111_0000, s1);
                issue(1, 1'b1, 1'b1, 32'h14, 32'h2222_0000, s1);
                issue(1, 1'b1, 1'b0, 32'h18, 32'h3333_0000, s1);
            end
            issue(0, 1'b0, 1'b0, 32'h14, 32'h0, s0);
        join
        check("lock_stalls_r0", 64'(s0), 64'd3);

        // Lock owner goes idle: the other requester waits out the timeout.
        fork
            issue(1, 1'b1, 1'b1, 32'h20, 32'h4444_0000, s1);
            begin @(posedge clk); #1; issue(0, 1'b0, 1'b0, 32'h20, 32'h0, s0); end
        join
        check("timeout_stalls_r0", 64'(s0), 64'(LOCK_TIMEOUT));

        // Misaligned and out-of-range, plus the last legal word.
        issue(0, 1'b0, 1'b0, 32'h06, 32'h0, s0);
        check("misaligned_err", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({1'b1, 32'h0}));
        issue(0, 1'b0, 1'b0, 32'h80, 32'h0, s0);
        check("range_err", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({1'b1, 32'h0}));
        issue(0, 1'b1, 1'b0, 32'h7C, 32'hCAFE_F00D, s0);
        issue(0, 1'b0, 1'b0, 32'h7C, 32'h0, s0);
        check("last_word_rdata", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({1'b0, 32'hCAFE_F00D}));

        // Reset right after a read is accepted, with a write request held during reset.
        issue(0, 1'b0, 1'b0, 32'h08, 32'h0, s0);
        reset = 1'b1;
        bus.req_we[1] = 1'b1; bus.req_lock[1] = 1'b0;
        bus.req_addr[1] = 32'h0C; bus.req_wdata[1] = 32'h1234_5678;
        bus.req_valid[1] = 1'b1;
        #1 check("rsp_dropped", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid[1] = 1'b0;
        check("post_reset_state", 64'(dbg_state), 64'(ARB));
        check("post_reset_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("post_reset_rsp", 64'(bus.rsp_valid), 64'd0);

        // Random traffic from both requesters.
        fork
            rand_traffic(0, 300);
            rand_traffic(1, 300);
        join
        repeat (LOCK_TIMEOUT + 4) @(posedge clk);
        #3 check("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port, word-addressed data memory.
- Shares that memory between requester 0 (core load/store unit) and requester 1 (loader/DMA/debug port).
- Per-requester valid/ready request handshake and registered response.
- Round-robin fairness, optional bus lock for bursts, and alignment/range checking before any memory access.

Parameters:
- DATA_W, 32, data width of requests, responses and memory.
- DEPTH, 32, memory depth in words; legal word index 0..DEPTH-1.
- LOCK_TIMEOUT, 8, idle cycles of lock owner before the lock is forcibly released (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit n = requester n)
- req_ready  out  2  per-requester request accepted this cycle
- req_we  in  2  1 = write, 0 = read
- req_lock  in  2  keep grant after this transfer
- req_addr  in  2x32  byte address per requester
- req_wdata  in  2xDATA_W  write data per requester
- rsp_valid  out  2  one-cycle response pulse per requester
- rsp_err  out  1  response is an error (qualified by rsp_valid)
- rsp_rdata  out  DATA_W  read data (qualified by rsp_valid, read only)
- mem_write  out  1  to memory write enable
- mem_read  out  1  to memory read enable
- mem_addr  out  32  to memory byte address
- mem_wd  out  DATA_W  to memory write data
- mem_rd  in  DATA_W  from memory, combinational read data

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state=ARB; rr_ptr=0 (requester 0 favoured first); lock counter 0; any pending response is discarded and rsp_valid=0 the cycle after reset.
- At most one transfer accepted per cycle.
- req_ready[n] asserts only in the cycle requester n is granted while req_valid[n]=1. Transfer occurs when req_valid&req_ready.
- Requesters must hold valid/we/addr/wdata stable until accepted.
- FSM state ARB:
  - Only one valid: grant it.
  - Both valid: grant requester rr_ptr; rr_ptr toggles to the other requester after every accepted transfer.
  - If the accepted transfer has req_lock=1, go to LOCK with owner=granted requester, counter cleared.
- FSM state LOCK:
  - Only the owner can be granted; the other requester stalls (ready=0).
  - Owner accepted with req_lock=0: return to ARB; rr_ptr points to the non-owner.
  - Owner valid=0: counter increments. When the counter reaches LOCK_TIMEOUT, return to ARB the next cycle.
  - Owner transfer accepted: counter clears.
- Address check (combinational, on the granted request):
  - misaligned (addr[1:0]!=0) or out of range ((addr>>2)>=DEPTH) means error.
  - Error transfers are accepted normally but mem_write=mem_read=0; response has rsp_err=1, rsp_rdata=0.
- Memory drive, same cycle as acceptance:
  - mem_addr and mem_wd come from the granted requester.
  - mem_write=we&legal; mem_read=~we&legal.
  - All mem_* are 0 when nothing is accepted.
- Response latency: exactly 1 cycle after acceptance.
  - rsp_valid[n] pulses for the accepted requester.
  - rsp_rdata is mem_rd registered at acceptance for reads, 0 for writes.
  - Writes also receive a response (rsp_err=0).
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data; the memory write completes at the accept edge.
- Back-to-back transfers: full throughput, one per cycle, with no bubble.
- Simultaneous reset and request: reset wins; nothing is accepted.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_e {ARB, LOCK}
  - constant NUM_REQ=2
  - function addr_legal(addr, DEPTH)
- Natural sub-module: rr_arbiter2 (2-input round-robin grant plus pointer update), reused by later bus arbiters.

Test Plan:
- Reset, then r0 writes 0xDEADBEEF to 0x08; next cycle r0 reads 0x08 → rsp_valid[0] one cycle after each accept; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Both valid continuously, reads to 0x00/0x04 → grants alternate 0,1,0,1; each requester sees rsp_valid every other cycle.
- r1 asserts lock for 3 writes (0x10,0x14,0x18) while r0 valid → r0 ready=0 for all 3. After r1's lock=0 transfer, r0 is granted the next cycle.
- r1 locks, then drops valid with LOCK_TIMEOUT=8 → r0 is still stalled for 8 cycles, then granted the following cycle.
- r0 reads 0x06 (misaligned) and 0x80 (DEPTH=32, out of range) → mem_read=0; responses have rsp_err=1, rsp_rdata=0.
- Assert reset in the cycle after a read is accepted → no rsp_valid pulse; FSM in ARB and rr_ptr=0 afterwards.
